// File: rtl/video_mixer_pkg.sv
// Shared types for the video layer mixer: frame bundle, shadow control
// word, pipeline latency and the per-channel 50% blend helper.
package video_mixer_pkg;

   localparam int RGB_W         = 12;
   localparam int CNT_W         = 10;
   localparam int MAX_LAYER     = 8;
   localparam int MIXER_LATENCY = 2;

   typedef struct packed {
      logic [CNT_W-1:0] hc;
      logic [CNT_W-1:0] vc;
      logic             start;
      logic [RGB_W-1:0] rgb;
   } vga_frame_t;

   typedef struct packed {
      logic [MAX_LAYER-1:0] en;
      logic [MAX_LAYER-1:0] blend;
      logic [RGB_W-1:0]     key;
      logic [RGB_W-1:0]     bg;
      logic                 bypass;
   } mixer_ctrl_t;

   function automatic logic [RGB_W-1:0] rgb_avg(
      input logic [RGB_W-1:0] a,
      input logic [RGB_W-1:0] b
   );
      logic [RGB_W-1:0] r;
      r = '0;
      for (int c = 0; c < 3; c++)
         r[c*4 +: 4] = (a[c*4 +: 4] >> 1) + (b[c*4 +: 4] >> 1);
      return r;
   endfunction

endpackage

// File: rtl/video_mixer_shadow.sv
// Frame-start loaded control register; the start pixel itself already
// sees the new word through ctrl_eff, later pixels see the register.
module video_mixer_shadow
   import video_mixer_pkg::*;
#(
   parameter logic [RGB_W-1:0] KEY_RST = 12'h0F0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  mixer_ctrl_t next,
   output mixer_ctrl_t ctrl_eff
);

   mixer_ctrl_t ctrl;

   // load on an advancing layer-0 start pixel, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl.en     <= '1;
         ctrl.blend  <= '0;
         ctrl.key    <= KEY_RST;
         ctrl.bg     <= '0;
         ctrl.bypass <= 1'b0;
      end else if (load) begin
         ctrl <= next;
      end
   end

   assign ctrl_eff = load ? next : ctrl;

endmodule

// File: rtl/video_layer_mixer.sv
// Two-stage priority/colour-key compositor over NUM_LAYER aligned streams.
// Optional 50% blend per layer: define VIDEO_LAYER_MIXER_BLEND_EN.
module video_layer_mixer
   import video_mixer_pkg::*;
#(
   parameter int               NUM_LAYER = 4,
   parameter logic [RGB_W-1:0] KEY_RST   = 12'h0F0,
   parameter int               ERR_CW    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        stall,
   input  logic                        bypass,
   input  logic [NUM_LAYER-1:0]        layer_en,
   input  logic [NUM_LAYER-1:0]        layer_blend,
   input  logic [RGB_W-1:0]            key_color,
   input  logic [RGB_W-1:0]            bg_color,
   input  logic [NUM_LAYER-1:0]        source_vld,
   input  vga_frame_t [NUM_LAYER-1:0]  source_frame,
   output logic                        sink_vld,
   output vga_frame_t                  sink_frame,
   output logic                        misalign,
   output logic [ERR_CW-1:0]           misalign_cnt
);

   logic        adv;
   logic        load;
   mixer_ctrl_t nxt;
   mixer_ctrl_t ctrl_eff;

   assign adv  = ~stall;
   assign load = adv & source_vld[0] & source_frame[0].start;

   assign nxt.en     = MAX_LAYER'(layer_en);
   assign nxt.blend  = MAX_LAYER'(layer_blend);
   assign nxt.key    = key_color;
   assign nxt.bg     = bg_color;
   assign nxt.bypass = bypass;

   video_mixer_shadow #(.KEY_RST(KEY_RST)) u_shadow (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .next     (nxt),
      .ctrl_eff (ctrl_eff)
   );

   logic unused_ctrl;
   assign unused_ctrl = ^{ctrl_eff.en, ctrl_eff.blend};

   logic [NUM_LAYER-1:0] opq;
   logic                 ev;

   // per-layer opacity from the effective shadow word
   always_comb begin
      opq = '0;
      for (int i = 0; i < NUM_LAYER; i++)
         opq[i] = ctrl_eff.en[i] & source_vld[i] &
                  (source_frame[i].rgb != ctrl_eff.key);
   end

   // one event per cycle no matter how many layers disagree with layer 0
   always_comb begin
      ev = 1'b0;
      for (int i = 1; i < NUM_LAYER; i++)
         if (source_vld[i] && source_vld[0] &&
             (source_frame[i].hc    != source_frame[0].hc ||
              source_frame[i].vc    != source_frame[0].vc ||
              source_frame[i].start != source_frame[0].start))
            ev = 1'b1;
   end

   logic [NUM_LAYER-1:0] opq1;
   logic [RGB_W-1:0]     rgb1 [NUM_LAYER];
   logic [CNT_W-1:0]     hc1;
   logic [CNT_W-1:0]     vc1;
   logic                 st1;
   logic                 vld1;
   logic [RGB_W-1:0]     bg1;
   logic                 byp1;
`ifdef VIDEO_LAYER_MIXER_BLEND_EN
   logic [NUM_LAYER-1:0] blend1;
`endif

   // stage 1: capture opacity, colours, layer-0 timing and the control
   // fields stage 2 needs, so a new frame start cannot disturb them
   always_ff @(posedge clk) begin
      if (rst) begin
         opq1 <= '0;
         for (int i = 0; i < NUM_LAYER; i++) rgb1[i] <= '0;
         hc1  <= '0;
         vc1  <= '0;
         st1  <= 1'b0;
         vld1 <= 1'b0;
         bg1  <= '0;
         byp1 <= 1'b0;
`ifdef VIDEO_LAYER_MIXER_BLEND_EN
         blend1 <= '0;
`endif
      end else if (adv) begin
         opq1 <= opq;
         for (int i = 0; i < NUM_LAYER; i++)
            rgb1[i] <= source_frame[i].rgb;
         hc1  <= source_frame[0].hc;
         vc1  <= source_frame[0].vc;
         st1  <= source_frame[0].start;
         vld1 <= source_vld[0];
         bg1  <= ctrl_eff.bg;
         byp1 <= ctrl_eff.bypass;
`ifdef VIDEO_LAYER_MIXER_BLEND_EN
         blend1 <= ctrl_eff.blend[NUM_LAYER-1:0];
`endif
      end
   end

   logic [RGB_W-1:0] pix;

   // priority fold: higher layers overwrite lower ones, bg underneath
   always_comb begin
      pix = bg1;
      for (int i = 0; i < NUM_LAYER; i++)
         if (opq1[i]) begin
`ifdef VIDEO_LAYER_MIXER_BLEND_EN
            if (blend1[i]) pix = rgb_avg(pix, rgb1[i]);
            else           pix = rgb1[i];
`else
            pix = rgb1[i];
`endif
         end
      if (byp1) pix = rgb1[0];
   end

   // stage 2: output register
   always_ff @(posedge clk) begin
      if (rst) begin
         sink_vld   <= 1'b0;
         sink_frame <= '0;
      end else if (adv) begin
         sink_vld         <= vld1;
         sink_frame.hc    <= hc1;
         sink_frame.vc    <= vc1;
         sink_frame.start <= st1;
         sink_frame.rgb   <= pix;
      end
   end

   // sticky flag and saturating event counter, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign     <= 1'b0;
         misalign_cnt <= '0;
      end else if (adv && ev) begin
         misalign <= 1'b1;
         if (~&misalign_cnt) misalign_cnt <= misalign_cnt + 1'b1;
      end
   end

endmodule

// File: doc/video_layer_mixer.md
Name: video_layer_mixer

Overview:
Parametrised successor to the fixed serial core chain. It takes NUM_LAYER parallel video streams of type vga_frame_t, one per layer, all timed from one frame counter. It composites them into one output stream using per-layer enable, a transparent colour key and layer priority. Control changes take effect only at frame start, so the picture never tears; the block also flags layer streams whose timing does not line up.

Parameters:
NUM_LAYER, 4, number of input layers (2..8); layer 0 is the lowest priority and the timing reference, layer NUM_LAYER-1 is on top
RGB_W, 12, width of the rgb field of vga_frame_t (4 bits each for R, G, B)
KEY_RST, 12'h0F0, colour key loaded into the shadow register at reset
ERR_CW, 8, width of the misalignment error counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
stall  in  1  downstream backpressure; freezes the whole pipeline
bypass  in  1  when 1, output is layer 0 passed straight through (same latency)
layer_en  in  NUM_LAYER  requested enable per layer
layer_blend  in  NUM_LAYER  requested 50% blend per layer (used only with the optional feature)
key_color  in  RGB_W  requested transparent colour
bg_color  in  RGB_W  requested background colour
source_vld  in  NUM_LAYER  per-layer pixel valid
source_frame  in  vga_frame_t[NUM_LAYER]  per-layer frame fields hc, vc, start, rgb
sink_vld  out  1  output pixel valid
sink_frame  out  vga_frame_t  composited frame
misalign  out  1  sticky misalignment flag
misalign_cnt  out  ERR_CW  misalignment event count, saturating

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset values: sink_vld=0, sink_frame=0, misalign=0, misalign_cnt=0.
- Reset values of the shadow register: en=all ones, blend=0, key=KEY_RST, bg=0.
- Advance condition: adv = ~stall. When stall=1, every register holds, including the shadow and error registers.
- Shadow update: layer_en, layer_blend, key_color, bg_color and bypass are copied into the shadow register when adv & source_vld[0] & source_frame[0].start.
- Shadow timing: the start pixel itself is composited with the new values. All later pixels use the shadow register, never the live inputs.
- Stage 1 (registered when adv), for each layer i: opaque[i] = shadow_en[i] & source_vld[i] & (rgb_i != shadow_key).
- Stage 1 also registers all layer rgb values, plus layer 0 hc, vc, start and source_vld[0].
- Stage 2 (registered when adv): pix starts at shadow_bg, then folds from i=0 upward: if opaque[i] then pix = rgb_i.
- Stage 2 result: the highest opaque layer wins; if no layer is opaque, the output is bg.
- Output fields: sink_frame.hc, .vc and .start are layer 0's stage-1 values; sink_vld is the stage-1 copy of source_vld[0].
- Latency: exactly 2 advancing cycles from source to sink.
- Layer 0 invalid: the pixel is not valid, but it still moves through the pipe with sink_vld=0.
- Bypass (shadow value): sink_frame.rgb = layer 0 rgb unmodified, key ignored. Valid and timing fields are unchanged, latency stays 2.
- Misalignment check: any i>0 with adv & source_vld[i] & source_vld[0] and a mismatch from layer 0 in hc, vc or start counts as an event.
- Misalignment response: each event sets misalign and increments misalign_cnt by 1, saturating at all ones. Several mismatching layers in one cycle count as 1.
- Layer vld without layer 0: source_vld[i]=1 while source_vld[0]=0 is not checked.
- Clearing the error registers: only rst clears misalign and misalign_cnt.
- Reset mid-frame: the pipe flushes and the shadow returns to its reset values; output is fully correct from the next frame start.

Optional Feature:
Macro: VIDEO_LAYER_MIXER_BLEND_EN.
- Defined: in the stage-2 fold, an opaque layer with shadow_blend[i]=1 gives pix = per-channel (pix>>1)+(rgb_i>>1) (4-bit channels, truncating, no overflow possible). A blended layer 0 averages with bg.
- Undefined: layer_blend is ignored and no blend logic is synthesised; behaviour is as above.

Decomposition:
- video_mixer_pkg: typedef mixer_ctrl_t {en, blend, key, bg, bypass}, constant MIXER_LATENCY=2, function rgb_avg().
- vga_frame_t stays in vga.svh.
- Sub-module video_mixer_shadow: holds the mixer_ctrl_t register with frame-start load and the stall hold.

Test Plan (NUM_LAYER=3, RGB_W=12, KEY_RST=12'h0F0):
1. Priority: layers 0/1/2 rgb = 12'h111/12'h222/12'h333, all valid, all enabled -> sink rgb=12'h333, 2 cycles after input; layer_en=3'b011 at frame start -> 12'h222 from that start pixel onward.
2. Transparency and background: layer2 rgb=12'h0F0, layer1 invalid, layer0 rgb=12'h0F0, bg_color=12'hABC -> sink rgb=12'hABC; layer0 rgb=12'h111 -> 12'h111.
3. Frame-aligned update: change key_color and layer_en mid-frame -> output unchanged until the next start pixel, then new values apply exactly at that pixel.
4. Stall: assert stall for 5 cycles mid-line -> sink_vld and sink_frame held constant, no pixel lost or duplicated; the sequence resumes in order.
5. Misalignment: layer1 hc = layer0 hc+1 for 3 valid cycles, layer2 also mismatched in one of them -> misalign=1, misalign_cnt=3; force 300 events with ERR_CW=8 -> misalign_cnt saturates at 255.
6. Bypass and blend: with bypass=1 (latched at start), layer0 rgb=12'h0F0 -> sink 12'h0F0. With VIDEO_LAYER_MIXER_BLEND_EN, layer0 12'h000 opaque and layer1 12'hFFF blended -> 12'h777.
